// File: rtl/ddr3_cmd_arbiter.sv
// ddr3_cmd_arbiter: round-robin write/read scheduler onto the MIG app interface with in-order read tagging
module ddr3_cmd_arbiter #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int APP_ADDR_WIDTH  = 29,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 wr_fifo_empty,
  input  logic [ADDRESS_WIDTH-1:0]             wr_fifo_address,
  input  logic [DATA_WIDTH-1:0]                wr_fifo_data,
  output logic                                 wr_fifo_read,
  input  logic                                 rd_in_fifo_empty,
  input  logic [ADDRESS_WIDTH-1:0]             rd_in_fifo_address,
  output logic                                 rd_in_fifo_read,
  input  logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_out_fifo_free,
  output logic                                 rd_out_fifo_write,
  output logic [ADDRESS_WIDTH-1:0]             rd_out_fifo_address,
  output logic [DATA_WIDTH-1:0]                rd_out_fifo_data,
  output logic [APP_ADDR_WIDTH-1:0]            app_addr,
  output logic [2:0]                           app_cmd,
  output logic                                 app_en,
  input  logic                                 app_rdy,
  output logic [DATA_WIDTH-1:0]                app_wdf_data,
  output logic [DATA_WIDTH/8-1:0]              app_wdf_mask,
  output logic                                 app_wdf_wren,
  output logic                                 app_wdf_end,
  input  logic                                 app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]                app_rd_data,
  input  logic                                 app_rd_data_valid,
  output logic                                 busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding,
  output logic                                 rd_underflow
);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE} state_t;
  state_t state_q, state_d;
  logic last_rd_q, last_rd_d, hz_q, hz_d;
  logic app_en_q, app_en_d, wren_q, wren_d;
  logic [2:0] cmd_q, cmd_d;
  logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] head_q, tail_q;
  logic [ADDRESS_WIDTH-1:0] tag_mem [MAX_OUTSTANDING];
  logic [ADDRESS_WIDTH-1:0] raddr_q, sel_addr;
  logic rv_q, uf_q;
  logic wr_ok, rd_ok, hazard, grant_wr, grant_rd, push, pop, wr_done;
  logic unused_addr;
  assign wr_ok    = en & !wr_fifo_empty;
  assign rd_ok    = en & !rd_in_fifo_empty & (cnt_q < CW'(MAX_OUTSTANDING)) & (cnt_q < rd_out_fifo_free);
  assign hazard   = wr_ok & rd_ok & (wr_fifo_address[ADDRESS_WIDTH-1:4] == rd_in_fifo_address[ADDRESS_WIDTH-1:4]);
  assign grant_wr = (state_q == IDLE) & wr_ok & (!rd_ok | hazard | last_rd_q);
  assign grant_rd = (state_q == IDLE) & rd_ok & !grant_wr;
  assign push     = (state_q == RD_ISSUE) & app_rdy;
  assign pop      = app_rd_data_valid & (cnt_q != '0);
  // Write completes when neither the command nor the data handshake is still pending after this cycle
  assign wr_done  = (state_q == WR_ISSUE) & !(app_en_q & !app_rdy) & !(wren_q & !app_wdf_rdy);
  assign sel_addr = grant_wr ? wr_fifo_address : rd_in_fifo_address;
  assign unused_addr = ^sel_addr;
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    hz_d      = hz_q;
    app_en_d  = app_en_q & !app_rdy;
    wren_d    = wren_q & !app_wdf_rdy;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (grant_wr) begin
      state_d  = WR_ISSUE;
      hz_d     = hazard;
      app_en_d = 1'b1;
      wren_d   = 1'b1;
      cmd_d    = 3'b000;
      addr_d   = {sel_addr[APP_ADDR_WIDTH-1:4], 4'b0};
      wdata_d  = wr_fifo_data;
    end
    if (grant_rd) begin
      state_d  = RD_ISSUE;
      app_en_d = 1'b1;
      cmd_d    = 3'b001;
      addr_d   = {sel_addr[APP_ADDR_WIDTH-1:4], 4'b0};
    end
    // A hazard-forced write leaves the round-robin pointer untouched
    if (wr_done) begin
      state_d   = IDLE;
      last_rd_d = hz_q & last_rd_q;
    end
    if (push) begin
      state_d   = IDLE;
      last_rd_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b0;
      hz_q      <= 1'b0;
      app_en_q  <= 1'b0;
      wren_q    <= 1'b0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      rv_q      <= 1'b0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      hz_q      <= hz_d;
      app_en_q  <= app_en_d;
      wren_q    <= wren_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      head_q    <= head_q + PW'(pop);
      tail_q    <= tail_q + PW'(push);
      rv_q      <= pop;
      if (pop) begin
        rdata_q <= app_rd_data;
        raddr_q <= tag_mem[head_q];
      end
      uf_q      <= uf_q | (app_rd_data_valid & (cnt_q == '0));
    end
  always_ff @(posedge clk)
    if (push) tag_mem[tail_q] <= rd_in_fifo_address;
  assign wr_fifo_read        = wr_done;
  assign rd_in_fifo_read     = push;
  assign rd_out_fifo_write   = rv_q;
  assign rd_out_fifo_address = raddr_q;
  assign rd_out_fifo_data    = rdata_q;
  assign app_addr            = addr_q;
  assign app_cmd             = cmd_q;
  assign app_en              = app_en_q;
  assign app_wdf_data        = wdata_q;
  assign app_wdf_mask        = '0;
  assign app_wdf_wren        = wren_q;
  assign app_wdf_end         = wren_q;
  assign busy                = (state_q != IDLE) | (cnt_q != '0);
  assign rd_outstanding      = cnt_q;
  assign rd_underflow        = uf_q;
endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// tb_ddr3_cmd_arbiter: scoreboard bench with FWFT FIFO and MIG models around ddr3_cmd_arbiter
module tb_ddr3_cmd_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int CW = 4;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  typedef struct {logic [28:0] a; logic [DW-1:0] d;} wexp_t;
  typedef struct {int t; logic [28:0] a;} pend_t;
  logic clk = 0, rst = 1, en = 0;
  logic wr_fifo_empty = 1, wr_fifo_read, rd_in_fifo_empty = 1, rd_in_fifo_read;
  logic [AW-1:0] wr_fifo_address = '0, rd_in_fifo_address = '0, rd_out_fifo_address;
  logic [DW-1:0] wr_fifo_data = '0, rd_out_fifo_data, app_wdf_data, app_rd_data = '0;
  logic [CW-1:0] rd_out_fifo_free = 4'd8, rd_outstanding;
  logic rd_out_fifo_write, app_en, app_rdy = 1, app_wdf_wren, app_wdf_end, app_wdf_rdy = 1;
  logic app_rd_data_valid = 0, busy, rd_underflow;
  logic [28:0] app_addr;
  logic [2:0] app_cmd;
  logic [15:0] app_wdf_mask;
  wr_t wq[$];
  wexp_t wexp[$];
  logic [AW-1:0] rq[$];
  wr_t rexp[$];
  pend_t pend[$];
  bit glog[$];
  int tests = 0, fails = 0, cyc = 0, en_cyc = 0, wren_cyc = 0, wrpops = 0, rdw = 0, peak = 0;
  int ret_budget = -1;
  bit force_rv = 0;
  ddr3_cmd_arbiter dut (
    .clk(clk), .rst(rst), .en(en),
    .wr_fifo_empty(wr_fifo_empty), .wr_fifo_address(wr_fifo_address), .wr_fifo_data(wr_fifo_data),
    .wr_fifo_read(wr_fifo_read),
    .rd_in_fifo_empty(rd_in_fifo_empty), .rd_in_fifo_address(rd_in_fifo_address),
    .rd_in_fifo_read(rd_in_fifo_read),
    .rd_out_fifo_free(rd_out_fifo_free), .rd_out_fifo_write(rd_out_fifo_write),
    .rd_out_fifo_address(rd_out_fifo_address), .rd_out_fifo_data(rd_out_fifo_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .busy(busy), .rd_outstanding(rd_outstanding), .rd_underflow(rd_underflow)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [DW-1:0] data_for(input logic [28:0] aa);
    return {4{{3'b0, aa} ^ 32'hC3A5_0F00}};
  endfunction
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wq.push_back('{a, d});
    wexp.push_back('{{a[28:4], 4'b0}, d});
  endtask
  task automatic push_rd(input logic [AW-1:0] a);
    rq.push_back(a);
    rexp.push_back('{a, data_for({a[28:4], 4'b0})});
  endtask
  task automatic drive_fifo();
    wr_fifo_empty = (wq.size() == 0);
    if (wq.size() != 0) begin
      wr_fifo_address = wq[0].a;
      wr_fifo_data = wq[0].d;
    end
    rd_in_fifo_empty = (rq.size() == 0);
    if (rq.size() != 0) rd_in_fifo_address = rq[0];
  endtask
  task automatic step();
    wr_t e;
    pend_t p;
    drive_fifo();
    #1;
    if (app_en) en_cyc++;
    if (app_wdf_wren) wren_cyc++;
    if (app_en && app_rdy) begin
      glog.push_back(app_cmd == 3'b001);
      if (app_cmd == 3'b000) begin
        if (wexp.size() == 0) chk("wr_cmd_unexp", 1, 0);
        else chk("wr_addr", app_addr, wexp[0].a);
      end else pend.push_back('{cyc + 5, app_addr});
    end
    if (app_wdf_wren && app_wdf_rdy) begin
      if (wexp.size() == 0) chk("wr_dat_unexp", 1, 0);
      else chk("wr_data", app_wdf_data, wexp[0].d);
      chk("wr_end_mask", {app_wdf_end, app_wdf_mask}, {1'b1, 16'h0});
    end
    if (wr_fifo_read) begin
      wrpops++;
      if (wq.size() != 0) begin
        void'(wq.pop_front());
        void'(wexp.pop_front());
      end
    end
    if (rd_in_fifo_read && rq.size() != 0) void'(rq.pop_front());
    if (rd_out_fifo_write) begin
      rdw++;
      if (rexp.size() == 0) chk("rd_unexp", 1, 0);
      else begin
        e = rexp.pop_front();
        chk("rd_addr", rd_out_fifo_address, e.a);
        chk("rd_data", rd_out_fifo_data, e.d);
      end
    end
    if (int'(rd_outstanding) > peak) peak = int'(rd_outstanding);
    @(posedge clk);
    #1;
    cyc++;
    app_rd_data_valid = 0;
    if (force_rv) begin
      app_rd_data_valid = 1;
      app_rd_data = '1;
      force_rv = 0;
    end else if (pend.size() != 0 && pend[0].t <= cyc && ret_budget != 0) begin
      p = pend.pop_front();
      app_rd_data_valid = 1;
      app_rd_data = data_for(p.a);
      if (ret_budget > 0) ret_budget--;
    end
  endtask
  task automatic run_until_idle(input int max);
    bit quiet;
    quiet = 0;
    for (int i = 0; i < max; i++) begin
      quiet = wq.size() == 0 && rq.size() == 0 && pend.size() == 0 && !busy &&
              !rd_out_fifo_write && !app_rd_data_valid;
      if (quiet) break;
      step();
    end
    chk("idle_timeout", quiet, 1);
  endtask
  task automatic clr();
    en_cyc = 0; wren_cyc = 0; wrpops = 0; peak = 0;
    glog.delete();
  endtask
  initial begin
    logic [7:0] lv;
    repeat (2) step();
    chk("rst_strobes", {app_en, app_wdf_wren, app_wdf_end, wr_fifo_read, rd_in_fifo_read, rd_out_fifo_write}, 0);
    chk("rst_addr_cmd", {app_addr, app_cmd}, 0);
    chk("rst_wdata_mask", {app_wdf_data, app_wdf_mask}, 0);
    chk("rst_status", {busy, rd_outstanding, rd_underflow}, 0);
    rst = 0;
    en = 1;
    step();
    clr();
    push_wr(32'h0000_1234, {16{8'hA5}});
    run_until_idle(50);
    chk("w1_en_cycles", en_cyc, 1);
    chk("w1_wren_cycles", wren_cyc, 1);
    chk("w1_pops", wrpops, 1);
    chk("w1_cmd_seen", glog.size(), 1);
    clr();
    app_rdy = 0;
    push_wr(32'h0000_5678, {4{32'h1357_9BDF}});
    repeat (4) step();
    chk("w2_wren_cycles", wren_cyc, 1);
    chk("w2_no_early_pop", wrpops, 0);
    app_rdy = 1;
    step();
    chk("w2_pop_on_rdy", wrpops, 1);
    run_until_idle(50);
    chk("w2_en_cycles", en_cyc, 4);
    chk("w2_pops", wrpops, 1);
    clr();
    push_rd(32'h100);
    push_rd(32'h200);
    push_rd(32'h300);
    run_until_idle(100);
    chk("r3_peak", peak, 3);
    chk("r3_outstanding", rd_outstanding, 0);
    chk("r3_rexp_empty", rexp.size(), 0);
    clr();
    for (int i = 0; i < 4; i++) begin
      push_wr(32'h1000 + 32'(i) * 32'h10, {4{32'(i) + 32'hAB00}});
      push_rd(32'h2000 + 32'(i) * 32'h10);
    end
    run_until_idle(200);
    lv = '0;
    for (int i = 0; i < glog.size() && i < 8; i++) lv[i] = glog[i];
    chk("alt_count", glog.size(), 8);
    chk("alt_order", lv, 8'b1010_1010);
    chk("alt_rexp_empty", rexp.size(), 0);
    push_wr(32'h7000, {4{32'h7777_0000}});
    run_until_idle(50);
    clr();
    push_wr(32'h40, {4{32'h4040_4040}});
    push_rd(32'h40);
    run_until_idle(100);
    lv = '0;
    for (int i = 0; i < glog.size() && i < 8; i++) lv[i] = glog[i];
    chk("hz_count", glog.size(), 2);
    chk("hz_write_first", lv[1:0], 2'b10);
    ret_budget = 0;
    for (int i = 0; i < 10; i++) push_rd(32'h3000 + 32'(i) * 32'h10);
    repeat (30) step();
    chk("max_out", rd_outstanding, 8);
    chk("max_rq_left", rq.size(), 2);
    ret_budget = 1;
    repeat (10) step();
    chk("max_resume", rd_outstanding, 8);
    chk("max_rq_left2", rq.size(), 1);
    ret_budget = -1;
    run_until_idle(300);
    chk("max_rexp_empty", rexp.size(), 0);
    rd_out_fifo_free = 4'd2;
    ret_budget = 0;
    for (int i = 0; i < 4; i++) push_rd(32'h4000 + 32'(i) * 32'h10);
    repeat (20) step();
    chk("free_out", rd_outstanding, 2);
    chk("free_rq_left", rq.size(), 2);
    ret_budget = 1;
    repeat (10) step();
    chk("free_resume", rd_outstanding, 2);
    chk("free_rq_left2", rq.size(), 1);
    rd_out_fifo_free = 4'd8;
    ret_budget = -1;
    run_until_idle(200);
    chk("free_rexp_empty", rexp.size(), 0);
    clr();
    app_rdy = 0;
    push_wr(32'h8000, {4{32'h8888_1111}});
    repeat (2) step();
    chk("rstw_in_issue", app_en, 1);
    rst = 1;
    #1;
    chk("rstw_async_strobes", {app_en, app_wdf_wren, app_wdf_end, wr_fifo_read}, 0);
    step();
    chk("rstw_no_pop", wrpops, 0);
    rst = 0;
    app_rdy = 1;
    run_until_idle(50);
    chk("rstw_reissue_pop", wrpops, 1);
    rdw = 0;
    force_rv = 1;
    repeat (3) step();
    chk("uf_flag", rd_underflow, 1);
    chk("uf_no_write", rdw, 0);
    chk("uf_outstanding", rd_outstanding, 0);
    repeat (3) step();
    chk("uf_sticky", rd_underflow, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ddr3_cmd_arbiter.md
Name: ddr3_cmd_arbiter

Overview:
- Schedules memory traffic onto the single DDR3 MIG user (app_*) interface. Requesters are the write FIFO (address and data) and the read-in FIFO (address).
- Arbitrates round-robin between the two, with a read-after-write hazard override.
- Issues single-beat 128-bit commands and tracks outstanding reads in an internal address tag queue.
- Returns read data with its address to the read-out FIFO under credit control.

Parameters:
- ADDRESS_WIDTH, 32, byte address width from the request FIFOs
- DATA_WIDTH, 128, data width (one MIG beat)
- APP_ADDR_WIDTH, 29, MIG app_addr width
- MAX_OUTSTANDING, 8, tag queue depth / max in-flight reads (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en  in  1  allow new commands to start
- wr_fifo_empty  in  1  write FIFO empty (first-word-fall-through)
- wr_fifo_address  in  ADDRESS_WIDTH  head write address
- wr_fifo_data  in  DATA_WIDTH  head write data
- wr_fifo_read  out  1  pop write FIFO
- rd_in_fifo_empty  in  1  read-request FIFO empty (first-word-fall-through)
- rd_in_fifo_address  in  ADDRESS_WIDTH  head read address
- rd_in_fifo_read  out  1  pop read-request FIFO
- rd_out_fifo_free  in  $clog2(MAX_OUTSTANDING+1)  free read-out FIFO slots, saturated
- rd_out_fifo_write  out  1  push read-out FIFO
- rd_out_fifo_address  out  ADDRESS_WIDTH  address of returned data
- rd_out_fifo_data  out  DATA_WIDTH  returned data
- app_addr  out  APP_ADDR_WIDTH  MIG address
- app_cmd  out  3  000 write, 001 read
- app_en  out  1  command valid
- app_rdy  in  1  MIG command accept
- app_wdf_data  out  DATA_WIDTH  write data
- app_wdf_mask  out  DATA_WIDTH/8  byte mask (1 = masked)
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  last write beat
- app_wdf_rdy  in  1  MIG write-data accept
- app_rd_data  in  DATA_WIDTH  MIG read data
- app_rd_data_valid  in  1  MIG read data valid
- busy  out  1  state != IDLE or reads outstanding
- rd_outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight read count
- rd_underflow  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1): state IDLE; all app_* strobes 0; app_cmd=0; app_addr=0; app_wdf_data=0; app_wdf_mask=0; wr_fifo_read=0, rd_in_fifo_read=0, rd_out_fifo_write=0; rd_outstanding=0; tag queue empty; rd_underflow=0; last_grant=WRITE. Reset mid-transaction abandons it; no FIFO pop occurs.
- Address map: app_addr = address[APP_ADDR_WIDTH-1:0] with bits [3:0] forced 0.
- app_wdf_mask is always 0 (full 128-bit writes).
- FSM states: IDLE, WR_ISSUE, RD_ISSUE.
- IDLE eligibility:
  - wr_ok = en & !wr_fifo_empty
  - rd_ok = en & !rd_in_fifo_empty & rd_outstanding < MAX_OUTSTANDING & rd_outstanding < rd_out_fifo_free
- IDLE grant:
  - If both are eligible and the aligned addresses match ([ADDRESS_WIDTH-1:4]), write wins (hazard); last_grant is not updated.
  - Otherwise, if both are eligible, grant the one not equal to last_grant. A single eligible requester is granted.
  - On entry to the granted state, register app_addr, app_cmd, and the strobes; app_wdf_data is registered for writes.
- WR_ISSUE:
  - app_en=1, app_wdf_wren=1, app_wdf_end=1, all registered.
  - Command handshake = app_en & app_rdy; app_en drops the next cycle.
  - Data handshake = app_wdf_wren & app_wdf_rdy; wren and end drop the next cycle. The two handshakes complete independently, in any order or in the same cycle.
  - wr_fifo_read is combinational, high for exactly the cycle in which the last outstanding handshake completes; that cycle goes to IDLE and sets last_grant=WRITE.
- RD_ISSUE:
  - app_en=1 and app_cmd=001 until app_rdy.
  - In the accept cycle: rd_in_fifo_read=1 (combinational); push address to the tag queue; rd_outstanding+1; go to IDLE; last_grant=READ.
- Throughput: one idle cycle minimum between commands. Command latency from IDLE decision to app_en is 1 cycle.
- Read return:
  - app_rd_data_valid (never stalled) -> on the next cycle rd_out_fifo_write=1, rd_out_fifo_data = captured data, rd_out_fifo_address = tag queue head; pop tag; rd_outstanding-1.
  - Simultaneous accept and return leaves the count unchanged. Returns are in order.
- Read-valid with an empty tag queue: no write to the read-out FIFO; rd_underflow set until reset.
- en=0: no new grants; any command in WR_ISSUE/RD_ISSUE completes; outstanding reads still return.

Test Plan:
- Single write, addr 0x0000_1234, data 0xA5..A5, app_rdy/app_wdf_rdy=1 -> app_addr=0x1230, app_cmd=000, en/wren/end high 1 cycle, one wr_fifo_read, mask=0.
- Write with app_rdy delayed 3 cycles and app_wdf_rdy accepted on first cycle -> wren drops after 1 cycle, app_en held 4 cycles, wr_fifo_read only on the app_rdy cycle.
- Reads 0x100, 0x200, 0x300, data returned 5 cycles later -> rd_out_fifo_write ×3 in order with addresses 0x100/0x200/0x300; rd_outstanding peaks at 3 and returns to 0.
- Both FIFOs non-empty with distinct addresses, 4 entries each -> grants alternate W,R,W,R...; with the same address 0x40 at both heads -> write issued first.
- MAX_OUTSTANDING=8 with no returns, or rd_out_fifo_free=2 -> issuing stops at 8 or 2 reads respectively; resumes after one return.
- rst asserted during WR_ISSUE -> all strobes 0 immediately, no wr_fifo_read; app_rd_data_valid with an empty tag queue -> rd_underflow=1, no rd_out_fifo_write.
